// File: rtl/l2_cache_param.sv
// Parametrised set-associative write-back, write-allocate L2 cache with tree pseudo-LRU
// replacement. One request is in service at a time; pmem handshake is driven from the state.
module l2_cache_param #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic         eviction,
    output logic         l2hits_inc,
    output logic         l2misses_inc
);

    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned LW    = $clog2(WAYS);
    localparam int unsigned TW    = 12 - IDX;
    localparam int unsigned NODES = WAYS - 1;

    typedef enum logic [1:0] {StIdle, StLookup, StWriteback, StFill} state_e;

    state_e           state_q, state_d;
    logic [15:4]      addr_q;
    logic [127:0]     wdata_q;
    logic             write_q;
    logic             first_q;
    logic [LW-1:0]    victim_q;

    logic [TW-1:0]    tag_arr  [SETS][WAYS];
    logic [127:0]     data_arr [SETS][WAYS];
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAYS-1:0]  dirty_q  [SETS];
    logic [NODES-1:0] plru_q   [SETS];

    logic [IDX-1:0]   idx;
    logic [TW-1:0]    tag;
    logic             hit;
    logic [LW-1:0]    hit_way;
    logic             inv_found;
    logic [LW-1:0]    inv_way;
    logic [LW-1:0]    plru_way;
    logic [LW-1:0]    vic_way;
    logic [NODES-1:0] plru_upd;
    logic             unused_offset;

    assign idx           = addr_q[4+IDX-1:4];
    assign tag           = addr_q[15:4+IDX];
    assign unused_offset = ^mem_address[3:0];
    assign vic_way       = inv_found ? inv_way : plru_way;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_arr[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = LW'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = LW'(w);
            end
        end
    end

    // Walk the heap-ordered tree from the root: bit 0 -> lower half, 1 -> upper half.
    always_comb begin : plru_walk
        int unsigned node;
        logic        b;
        plru_way = '0;
        node     = 0;
        b        = 1'b0;
        for (int unsigned l = 0; l < LW; l++) begin
            b = 1'b0;
            for (int unsigned n = 0; n < NODES; n++) begin
                if (n == node) b = plru_q[idx][n];
            end
            plru_way = (plru_way << 1) | LW'(b);
            node     = 2 * node + (b ? 32'd2 : 32'd1);
        end
    end

    // On a hit every node along the path is pointed away from the accessed way.
    always_comb begin : plru_touch
        int unsigned   node;
        logic [LW-1:0] wtmp;
        logic          hb;
        plru_upd = plru_q[idx];
        node     = 0;
        wtmp     = hit_way;
        hb       = 1'b0;
        for (int unsigned l = 0; l < LW; l++) begin
            hb   = wtmp[LW-1];
            wtmp = wtmp << 1;
            for (int unsigned n = 0; n < NODES; n++) begin
                if (n == node) plru_upd[n] = ~hb;
            end
            node = 2 * node + (hb ? 32'd2 : 32'd1);
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        eviction     = 1'b0;
        l2hits_inc   = 1'b0;
        l2misses_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    mem_resp   = 1'b1;
                    mem_rdata  = data_arr[idx][hit_way];
                    l2hits_inc = first_q;
                    state_d    = StIdle;
                end else begin
                    l2misses_inc = 1'b1;
                    state_d = (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) ? StWriteback
                                                                                : StFill;
                end
            end
            StWriteback: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[idx][victim_q], idx, 4'b0000};
                pmem_wdata   = data_arr[idx][victim_q];
                if (pmem_resp) begin
                    eviction = 1'b1;
                    state_d  = StFill;
                end
            end
            StFill: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_q, 4'b0000};
                if (pmem_resp) state_d = StLookup;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            first_q  <= 1'b0;
            victim_q <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_address[15:4];
                        wdata_q <= mem_wdata;
                        write_q <= mem_write & ~mem_read;
                        first_q <= 1'b1;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        plru_q[idx] <= plru_upd;
                        if (write_q) dirty_q[idx][hit_way] <= 1'b1;
                    end else begin
                        first_q  <= 1'b0;
                        victim_q <= vic_way;
                    end
                end
                StWriteback: begin
                    if (pmem_resp) dirty_q[idx][victim_q] <= 1'b0;
                end
                StFill: begin
                    if (pmem_resp) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and tag storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (state_q == StLookup && hit && write_q) begin
            data_arr[idx][hit_way] <= wdata_q;
        end
        if (state_q == StFill && pmem_resp) begin
            data_arr[idx][victim_q] <= pmem_rdata;
            tag_arr[idx][victim_q]  <= tag;
        end
    end

endmodule

// File: tb/tb_l2_cache_param.sv
// Directed self-checking bench for l2_cache_param: a 4-way/8-set instance and a 2-way/16-set
// instance share stimulus, selected by sel; a line-addressed memory model answers pmem.
module tb_l2_cache_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, sel;
    logic         req_read, req_write, pm_resp;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata, pm_rdata;

    logic         a_resp, a_pread, a_pwrite, a_evict, a_hit, a_miss;
    logic [15:0]  a_paddr;
    logic [127:0] a_rdata, a_pwdata;
    logic         b_resp, b_pread, b_pwrite, b_evict, b_hit, b_miss;
    logic [15:0]  b_paddr;
    logic [127:0] b_rdata, b_pwdata;

    logic         o_resp, o_pread, o_pwrite, o_evict, o_hit, o_miss;
    logic [15:0]  o_paddr;
    logic [127:0] o_rdata, o_pwdata;

    l2_cache_param #(.WAYS(4), .SETS(8)) dut_a (
        .clk(clk), .reset(reset),
        .mem_read(req_read & ~sel), .mem_write(req_write & ~sel),
        .mem_address(req_addr), .mem_wdata(req_wdata),
        .mem_resp(a_resp), .mem_rdata(a_rdata),
        .pmem_resp(pm_resp & ~sel), .pmem_rdata(pm_rdata),
        .pmem_read(a_pread), .pmem_write(a_pwrite),
        .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
        .eviction(a_evict), .l2hits_inc(a_hit), .l2misses_inc(a_miss)
    );

    l2_cache_param #(.WAYS(2), .SETS(16)) dut_b (
        .clk(clk), .reset(reset),
        .mem_read(req_read & sel), .mem_write(req_write & sel),
        .mem_address(req_addr), .mem_wdata(req_wdata),
        .mem_resp(b_resp), .mem_rdata(b_rdata),
        .pmem_resp(pm_resp & sel), .pmem_rdata(pm_rdata),
        .pmem_read(b_pread), .pmem_write(b_pwrite),
        .pmem_address(b_paddr), .pmem_wdata(b_pwdata),
        .eviction(b_evict), .l2hits_inc(b_hit), .l2misses_inc(b_miss)
    );

    assign o_resp   = sel ? b_resp   : a_resp;
    assign o_rdata  = sel ? b_rdata  : a_rdata;
    assign o_pread  = sel ? b_pread  : a_pread;
    assign o_pwrite = sel ? b_pwrite : a_pwrite;
    assign o_paddr  = sel ? b_paddr  : a_paddr;
    assign o_pwdata = sel ? b_pwdata : a_pwdata;
    assign o_evict  = sel ? b_evict  : a_evict;
    assign o_hit    = sel ? b_hit    : a_hit;
    assign o_miss   = sel ? b_miss   : a_miss;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_model [4096];

    int           r_lat, r_hits, r_misses, r_evicts, r_nwb, r_nfill;
    logic [15:0]  r_wb_addr, r_fill_addr;
    logic [127:0] r_rdata, r_wb_data;
    logic         r_glitch, r_timeout;

    localparam logic [127:0] LineA5 = {16{8'hA5}};
    localparam logic [127:0] LineD  = {8{16'hDEAD}};
    localparam logic [127:0] LineW1 = {8{16'h1111}};
    localparam logic [127:0] LineW2 = {8{16'hBEEF}};

    function automatic logic [127:0] pat(input logic [11:0] l);
        return {8{l, 4'h5}};
    endfunction

    // Present one request and serve pmem until mem_resp; the request is left asserted.
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [127:0] wd,
                          input int wait_cycles, input logic jitter);
        int          cyc, cnt;
        logic        done, was_busy;
        logic [15:0] last_paddr;
        r_lat = -1; r_hits = 0; r_misses = 0; r_evicts = 0; r_nwb = 0; r_nfill = 0;
        r_wb_addr = '0; r_fill_addr = '0; r_rdata = '0; r_wb_data = '0;
        r_glitch = 1'b0; r_timeout = 1'b0;
        @(negedge clk);
        req_read = ~wr; req_write = wr; req_addr = addr; req_wdata = wd; pm_resp = 1'b0;
        cyc = 0; cnt = 0; done = 1'b0; was_busy = 1'b0; last_paddr = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (jitter) req_addr = req_addr ^ 16'hFFF0;
            pm_resp = 1'b0;
            if (o_pread || o_pwrite) begin
                if (o_pread && o_pwrite) r_glitch = 1'b1;
                if (was_busy && o_paddr !== last_paddr) r_glitch = 1'b1;
                last_paddr = o_paddr;
                was_busy = 1'b1;
                if (cnt == wait_cycles) begin
                    pm_resp = 1'b1; cnt = 0; was_busy = 1'b0;
                    if (o_pwrite) begin
                        r_nwb++; r_wb_addr = o_paddr; r_wb_data = o_pwdata;
                        mem_model[o_paddr[15:4]] = o_pwdata;
                    end else begin
                        r_nfill++; r_fill_addr = o_paddr;
                        pm_rdata = mem_model[o_paddr[15:4]];
                    end
                end else begin
                    cnt++;
                end
            end
            #1;
            r_hits   = r_hits + (o_hit ? 1 : 0);
            r_misses = r_misses + (o_miss ? 1 : 0);
            r_evicts = r_evicts + (o_evict ? 1 : 0);
            if (o_resp) begin
                r_lat = cyc; r_rdata = o_rdata; done = 1'b1;
            end
        end
        if (!done) begin
            r_timeout = 1'b1;
            req_read = 1'b0; req_write = 1'b0; pm_resp = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0; pm_resp = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 1'b0; req_read = 1'b0; req_write = 1'b0; pm_resp = 1'b0;
        req_addr = '0; req_wdata = '0; pm_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({o_resp, o_pread, o_pwrite, o_evict, o_hit, o_miss} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b want 000000",
                     {o_resp, o_pread, o_pwrite, o_evict, o_hit, o_miss});
        end
        checks++;
        if ({o_paddr, o_pwdata, o_rdata} !== '0) begin
            errors++; $display("FAIL reset_data_a: got %h want 0", {o_paddr, o_pwdata, o_rdata});
        end
        sel = 1'b1;
        #1;
        checks++;
        if ({o_resp, o_pread, o_pwrite, o_evict, o_hit, o_miss, o_paddr} !== '0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0",
                     {o_resp, o_pread, o_pwrite, o_evict, o_hit, o_miss, o_paddr});
        end
        sel = 1'b0;
    endtask

    task automatic test_cold_read();
        mem_model[12'h123] = LineA5;
        do_req(1'b0, 16'h1230, '0, 5, 1'b0);
        checks++;
        if (r_misses !== 1 || r_hits !== 0) begin
            errors++; $display("FAIL cold_pulses: got hit %0d miss %0d want 0 1", r_hits, r_misses);
        end
        checks++;
        if (r_nfill !== 1 || r_fill_addr !== 16'h1230 || r_nwb !== 0) begin
            errors++;
            $display("FAIL cold_fill: got fills %0d addr %h wb %0d want 1 1230 0",
                     r_nfill, r_fill_addr, r_nwb);
        end
        checks++;
        if (r_lat !== 8) begin errors++; $display("FAIL cold_lat: got %0d want 8", r_lat); end
        checks++;
        if (r_rdata !== LineA5) begin
            errors++; $display("FAIL cold_rdata: got %h want %h", r_rdata, LineA5);
        end
        checks++;
        if (r_glitch !== 1'b0 || r_timeout !== 1'b0) begin
            errors++; $display("FAIL cold_pmem: got glitch %b timeout %b want 0 0", r_glitch, r_timeout);
        end
        idle();
        do_req(1'b0, 16'h1230, '0, 0, 1'b0);
        checks++;
        if (r_lat !== 1 || r_hits !== 1 || r_misses !== 0) begin
            errors++;
            $display("FAIL reread_hit: got lat %0d hit %0d miss %0d want 1 1 0", r_lat, r_hits, r_misses);
        end
        checks++;
        if (r_nfill !== 0 || r_nwb !== 0 || r_rdata !== LineA5) begin
            errors++;
            $display("FAIL reread_data: got fills %0d wb %0d data %h want 0 0 %h",
                     r_nfill, r_nwb, r_rdata, LineA5);
        end
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 16'h1230, LineW1, 0, 1'b0);
        checks++;
        if (r_lat !== 1 || r_hits !== 1) begin
            errors++; $display("FAIL b2b_write: got lat %0d hit %0d want 1 1", r_lat, r_hits);
        end
        do_req(1'b0, 16'h1230, '0, 0, 1'b0);
        checks++;
        if (r_lat !== 1 || r_hits !== 1 || r_rdata !== LineW1) begin
            errors++;
            $display("FAIL b2b_read: got lat %0d hit %0d data %h want 1 1 %h",
                     r_lat, r_hits, r_rdata, LineW1);
        end
        idle();
    endtask

    task automatic test_dirty_evict();
        int miss_sum, wb_sum;
        do_req(1'b1, 16'h0000, LineD, 2, 1'b0);
        checks++;
        if (r_lat !== 5 || r_misses !== 1 || r_nfill !== 1) begin
            errors++;
            $display("FAIL wmiss: got lat %0d miss %0d fills %0d want 5 1 1", r_lat, r_misses, r_nfill);
        end
        idle();
        miss_sum = 0; wb_sum = 0;
        for (int i = 1; i < 4; i++) begin
            do_req(1'b0, 16'(i * 128), '0, 0, 1'b0);
            miss_sum += r_misses; wb_sum += r_nwb;
            idle();
        end
        checks++;
        if (miss_sum !== 3 || wb_sum !== 0) begin
            errors++; $display("FAIL fill_set: got miss %0d wb %0d want 3 0", miss_sum, wb_sum);
        end
        do_req(1'b0, 16'h0200, '0, 1, 1'b0);
        checks++;
        if (r_nwb !== 1 || r_wb_addr !== 16'h0000 || r_wb_data !== LineD) begin
            errors++;
            $display("FAIL evict_wb: got wb %0d addr %h data %h want 1 0000 %h",
                     r_nwb, r_wb_addr, r_wb_data, LineD);
        end
        checks++;
        if (r_evicts !== 1) begin errors++; $display("FAIL evict_pulse: got %0d want 1", r_evicts); end
        checks++;
        if (r_nfill !== 1 || r_fill_addr !== 16'h0200 || r_rdata !== pat(12'h020)) begin
            errors++;
            $display("FAIL evict_fill: got fills %0d addr %h data %h want 1 0200 %h",
                     r_nfill, r_fill_addr, r_rdata, pat(12'h020));
        end
        checks++;
        if (r_lat !== 6 || r_glitch !== 1'b0) begin
            errors++; $display("FAIL evict_lat: got lat %0d glitch %b want 6 0", r_lat, r_glitch);
        end
        idle();
    endtask

    task automatic test_write_hit();
        int wb_sum;
        do_req(1'b1, 16'h0080, LineW2, 0, 1'b0);
        checks++;
        if (r_lat !== 1 || r_hits !== 1 || r_nfill !== 0 || r_nwb !== 0) begin
            errors++;
            $display("FAIL whit: got lat %0d hit %0d fills %0d wb %0d want 1 1 0 0",
                     r_lat, r_hits, r_nfill, r_nwb);
        end
        idle();
        wb_sum = 0;
        for (int i = 5; i < 8; i++) begin
            do_req(1'b0, 16'(i * 128), '0, 0, 1'b0);
            wb_sum += r_nwb;
            idle();
        end
        checks++;
        if (wb_sum !== 0) begin errors++; $display("FAIL whit_clean: got wb %0d want 0", wb_sum); end
        do_req(1'b0, 16'h0400, '0, 0, 1'b0);
        checks++;
        if (r_nwb !== 1 || r_wb_addr !== 16'h0080 || r_wb_data !== LineW2) begin
            errors++;
            $display("FAIL whit_wb: got wb %0d addr %h data %h want 1 0080 %h",
                     r_nwb, r_wb_addr, r_wb_data, LineW2);
        end
        idle();
    endtask

    task automatic test_reset_fill();
        logic seen;
        @(negedge clk);
        req_read = 1'b1; req_addr = 16'h1240;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (o_pread) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL rst_fill_reach: got %b want 1", seen); end
        @(negedge clk);
        reset = 1'b1; req_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({o_resp, o_pread, o_pwrite, o_evict, o_hit, o_miss, o_paddr, o_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_fill_out: got %b %b %b %h want all 0",
                     o_resp, o_pread, o_pwrite, o_paddr);
        end
        @(negedge clk);
        pm_resp = 1'b1;
        #1;
        checks++;
        if ({o_resp, o_pread, o_pwrite, o_evict} !== 4'b0) begin
            errors++;
            $display("FAIL rst_stray: got %b want 0000", {o_resp, o_pread, o_pwrite, o_evict});
        end
        @(negedge clk);
        pm_resp = 1'b0;
        do_req(1'b0, 16'h1240, '0, 0, 1'b0);
        checks++;
        if (r_misses !== 1 || r_nfill !== 1 || r_rdata !== pat(12'h124)) begin
            errors++;
            $display("FAIL rst_refill: got miss %0d fills %0d data %h want 1 1 %h",
                     r_misses, r_nfill, r_rdata, pat(12'h124));
        end
        idle();
        do_req(1'b0, 16'h1230, '0, 0, 1'b0);
        checks++;
        if (r_misses !== 1 || r_nwb !== 0 || r_rdata !== LineA5) begin
            errors++;
            $display("FAIL rst_invalidate: got miss %0d wb %0d data %h want 1 0 %h",
                     r_misses, r_nwb, r_rdata, LineA5);
        end
        idle();
    endtask

    task automatic test_stall();
        do_req(1'b0, 16'h2000, '0, 20, 1'b1);
        checks++;
        if (r_lat !== 23) begin errors++; $display("FAIL stall_lat: got %0d want 23", r_lat); end
        checks++;
        if (r_glitch !== 1'b0 || r_nfill !== 1 || r_fill_addr !== 16'h2000) begin
            errors++;
            $display("FAIL stall_pmem: got glitch %b fills %0d addr %h want 0 1 2000",
                     r_glitch, r_nfill, r_fill_addr);
        end
        checks++;
        if (r_rdata !== pat(12'h200)) begin
            errors++; $display("FAIL stall_rdata: got %h want %h", r_rdata, pat(12'h200));
        end
        idle();
    endtask

    // Two ways: true LRU, kept as a two-entry table with a most-recently-used pointer.
    task automatic test_alt_geometry();
        logic [15:0]  seq [8];
        logic [15:0]  m_addr [2];
        logic [127:0] m_data [2];
        logic         m_val  [2];
        int           mru, v, exp_hits, got_hits;
        logic         exp_hit;
        logic [127:0] d;
        seq = '{16'h0000, 16'h0100, 16'h0000, 16'h0200, 16'h0100, 16'h0200, 16'h0000, 16'h0000};
        m_val = '{1'b0, 1'b0}; m_addr = '{16'h0, 16'h0}; m_data = '{128'h0, 128'h0};
        mru = 0; exp_hits = 0; got_hits = 0;
        @(negedge clk);
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = {16{8'(i + 16)}};
            do_req(1'b1, seq[i], d, 1, 1'b0);
            exp_hit = 1'b0; v = 0;
            for (int k = 0; k < 2; k++) begin
                if (m_val[k] && m_addr[k] == seq[i]) begin exp_hit = 1'b1; v = k; end
            end
            if (!exp_hit) v = !m_val[0] ? 0 : (!m_val[1] ? 1 : 1 - mru);
            checks++;
            if (r_hits !== (exp_hit ? 1 : 0) || r_misses !== (exp_hit ? 0 : 1)) begin
                errors++;
                $display("FAIL alt_pulse[%0d]: got hit %0d miss %0d want hit %b", i, r_hits,
                         r_misses, exp_hit);
            end
            if (!exp_hit && m_val[v]) begin
                checks++;
                if (r_nwb !== 1 || r_wb_addr !== m_addr[v] || r_wb_data !== m_data[v]) begin
                    errors++;
                    $display("FAIL alt_victim[%0d]: got wb %0d addr %h want 1 %h", i, r_nwb,
                             r_wb_addr, m_addr[v]);
                end
            end else begin
                checks++;
                if (r_nwb !== 0) begin
                    errors++; $display("FAIL alt_nowb[%0d]: got %0d want 0", i, r_nwb);
                end
            end
            exp_hits += exp_hit ? 1 : 0;
            got_hits += r_hits;
            m_val[v] = 1'b1; m_addr[v] = seq[i]; m_data[v] = d; mru = v;
            idle();
        end
        checks++;
        if (got_hits !== exp_hits) begin
            errors++; $display("FAIL alt_hit_total: got %0d want %0d", got_hits, exp_hits);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = pat(12'(i));
        test_reset();
        test_cold_read();
        test_back_to_back();
        test_dirty_evict();
        test_write_hit();
        test_reset_fill();
        test_stall();
        test_alt_geometry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
